fifo_wr_arb: RTL and testbench
==============================

// Module: fifo_wr_arb
// PURPOSE
//   Round-robin write-port arbiter for the asynchronous FIFO. Shares the single
//   write side (winc/wdata, gated by wfull) among NREQ requesters in the write
//   clock domain. Grants one requester at a time for a burst of up to MAXBURST
//   words. The FIFO's full/empty comparison logic and read side are unchanged.
// PARAMETERS
//   NREQ      4   number of requesters (2..8)
//   DSIZE     8   data word width, equals FIFO DSIZE
//   MAXBURST  4   max words per grant (1..16)
//   IDW       derived = clog2(NREQ); width of grant_id, not user-set
// PORTS
//   wclk       in   1           write-domain clock, all logic on posedge
//   wrst       in   1           asynchronous, active-high reset
//   req_valid  in   NREQ        per-requester word valid
//   req_last   in   NREQ        per-requester "final word of burst" flag
//   req_data   in   NREQ*DSIZE  packed data; requester i at [i*DSIZE +: DSIZE]
//   req_ready  out  NREQ        per-requester accept; one-hot or zero
//   wfull      in   1           FIFO full flag (registered, wclk domain)
//   winc       out  1           FIFO write enable
//   wdata      out  DSIZE       FIFO write data
//   grant_id   out  IDW         index of current owner (valid when busy)
//   busy       out  1           1 while a requester owns the port
// BEHAVIOUR
//   Reset (async on wrst=1): state=IDLE, grant_id=0, rr_ptr=0, burst_cnt=0,
//     busy=0. While reset is asserted: req_ready=0, winc=0, wdata=0.
//   Handshake: transfer on requester i when req_valid[i] & req_ready[i] at posedge.
//     A requester holds valid/data/last stable until it is accepted.
//   Combinational: req_ready[i] = busy & (grant_id==i) & ~wfull;
//     winc = req_valid[grant_id] & req_ready[grant_id];
//     wdata = req_data[grant_id] when busy, else 0. No added latency to the FIFO.
//   FSM, 2 states:
//     IDLE: busy=0. If any req_valid: choose the first set bit searching
//       cyclically from rr_ptr upward. Register grant_id=winner, burst_cnt=0,
//       and go to OWN. With no valid, stay in IDLE.
//     OWN: busy=1. On a transfer, burst_cnt++. Release (-> IDLE, rr_ptr=grant_id+1
//       mod NREQ) when:
//       (a) the transfer has req_last=1, or
//       (b) the transfer has burst_cnt==MAXBURST-1, or
//       (c) req_valid[grant_id]=0 (owner idle; no transfer in that cycle).
//   Latency: valid rises in IDLE at cycle t -> grant at t+1 -> first winc at t+1
//     if ~wfull. Each owner change costs one IDLE bubble cycle.
//   wfull=1 in OWN: req_ready=0, winc=0, burst_cnt holds, grant held. No release
//     on full alone. Never writes while wfull=1, so the FIFO cannot overflow.
//   Simultaneous requests: the winner is the lowest index at or after rr_ptr.
//     A just-released owner has lowest priority in the next arbitration.
//   NREQ not a power of 2: rr_ptr and grant_id wrap NREQ-1 -> 0. Out-of-range
//     indices are never granted.
//   Reset mid-burst: burst is abandoned, no further winc. Words already written
//     remain in the FIFO; FIFO pointer reset is the FIFO's concern.
//   burst_cnt width = clog2(MAXBURST)+1. No overflow, because release at MAXBURST.
// TESTING
//   1. Reset: wrst=1 with all valids high -> req_ready=0, winc=0, busy=0.
//      Release -> req 0 granted in the cycle after.
//   2. Single req 2, 6 words, last on 6th, MAXBURST=4 -> 4 words, IDLE bubble,
//      re-grant to 2 (only requester), 2 words. winc count=6, data in order.
//   3. All 4 valid continuously, last every word -> grant order 0,1,2,3,0...
//      one word per 2 cycles.
//   4. Owner 1 mid-burst, force wfull=1 for 5 cycles -> winc=0, grant_id=1 held,
//      burst_cnt frozen. Resumes on wfull=0 with no word lost or duplicated.
//   5. Owner 3 drops valid after 1 word -> release next cycle, rr_ptr=0.
//      Pending req 0 is granted.
//   6. Assert wrst for 1 cycle mid-burst of req 2 -> winc=0 immediately,
//      state IDLE. Arbitration restarts from req 0.

Source files
------------

// File: rtl/fifo_wr_arb_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO write port.
// The arbiter side is the master: it drives the accepts and the FIFO write strobe/data.
interface fifo_wr_arb_if #(
  parameter int NREQ  = 4,
  parameter int DSIZE = 8,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_last;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  winc;
  logic [DSIZE-1:0]      wdata;
  logic [IDW-1:0]        grant_id;
  logic                  busy;

  modport master (
    input  req_valid, req_last, req_data, wfull,
    output req_ready, winc, wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_last, req_data, wfull,
    input  req_ready, winc, wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the FIFO write port among NREQ requesters, one burst
// of up to MAXBURST words per grant, with one idle arbitration cycle between owners.
module fifo_wr_arb #(
  parameter int  NREQ     = 4,
  parameter int  DSIZE    = 8,
  parameter int  MAXBURST = 4,
  localparam int IDW      = $clog2(NREQ),
  localparam int CW       = $clog2(MAXBURST) + 1
) (
  input  logic           wclk,
  input  logic           wrst,
  fifo_wr_arb_if.master  wr,
  output logic           dbg_state_o,
  output logic [CW-1:0]  dbg_burst_cnt_o,
  output logic [IDW-1:0] dbg_rr_ptr_o
);

  // Valid/ready: requester i's word moves when req_valid[i] & req_ready[i] at posedge
  // wclk; a requester keeps valid, data and last stable until that happens.

  localparam logic [0:0]     S_IDLE    = 1'b0;
  localparam logic [0:0]     S_OWN     = 1'b1;
  localparam logic [IDW-1:0] LAST_IDX  = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  BURST_END = CW'(MAXBURST - 1);
  localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);

  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [IDW-1:0] rr_q, rr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           busy;
  logic           owner_valid;
  logic           owner_last;
  logic           xfer;
  logic [IDW-1:0] next_ptr;
  logic           found;
  logic [IDW-1:0] winner;

  assign busy        = (state_q == S_OWN);
  assign owner_valid = wr.req_valid[grant_q];
  assign owner_last  = wr.req_last[grant_q];
  assign xfer        = busy & owner_valid & ~wr.wfull;
  assign next_ptr    = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  // Cyclic search from rr_ptr; the sum wraps at NREQ so unused indices never win.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      logic [IDW:0]   sum;
      logic [IDW-1:0] cand;
      sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      cand = sum[IDW-1:0];
      if (!found && wr.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_OWN;
          grant_d = winner;
          cnt_d   = '0;
        end
      end
      S_OWN: begin
        if (!owner_valid) begin
          state_d = S_IDLE;
          rr_d    = next_ptr;
          cnt_d   = '0;
        end else if (xfer) begin
          if (owner_last || cnt_q == BURST_END) begin
            state_d = S_IDLE;
            rr_d    = next_ptr;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write side is purely combinational from the owner so the FIFO sees no extra latency.
  always_comb begin
    wr.req_ready = '0;
    wr.wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (busy && grant_q == IDW'(i)) begin
        wr.req_ready[i] = ~wr.wfull;
        wr.wdata        = wr.req_data[i*DSIZE +: DSIZE];
      end
    end
  end

  assign wr.winc     = xfer;
  assign wr.grant_id = grant_q;
  assign wr.busy     = busy;

  assign dbg_state_o     = state_q[0];
  assign dbg_burst_cnt_o = cnt_q;
  assign dbg_rr_ptr_o    = rr_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus a random phase, all outputs checked each
// cycle against a burst-level round-robin model and an in-order write scoreboard.
module tb_fifo_wr_arb;
  localparam int NREQ     = 4;
  localparam int DSIZE    = 8;
  localparam int MAXBURST = 4;
  localparam int IDW      = $clog2(NREQ);
  localparam int CW       = $clog2(MAXBURST) + 1;
  localparam int DEPTH    = 64;

  // ---------------- clock / reset ----------------
  logic           wclk = 1'b0;
  logic           wrst;
  logic           dbg_state;
  logic [CW-1:0]  dbg_cnt;
  logic [IDW-1:0] dbg_rr;

  always #5 wclk = ~wclk;

  fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE), .IDW(IDW)) bus ();

  fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST)) dut (
    .wclk            (wclk),
    .wrst            (wrst),
    .wr              (bus),
    .dbg_state_o     (dbg_state),
    .dbg_burst_cnt_o (dbg_cnt),
    .dbg_rr_ptr_o    (dbg_rr)
  );

  // ---------------- stimulus storage / model / scoreboard ----------------
  logic [DSIZE:0]   words[NREQ][DEPTH];   // {last, data}
  int               head[NREQ];
  int               tail[NREQ];
  int               valid_pct;
  int               full_pct;
  int               m_owner;              // -1: nobody owns the port
  int               m_rr;
  int               m_cnt;
  logic [DSIZE-1:0] exp_q[$];
  int               grant_log[$];
  int               winc_cnt;
  int               checks;
  int               failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_word(input int r, input logic [DSIZE-1:0] d, input logic l);
    words[r][tail[r]] = {l, d};
    tail[r]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] && head[i] < tail[i] && $urandom_range(0, 99) < valid_pct) begin
        bus.req_valid[i]                 = 1'b1;
        bus.req_data[i*DSIZE +: DSIZE]   = words[i][head[i]][DSIZE-1:0];
        bus.req_last[i]                  = words[i][head[i]][DSIZE];
      end
    end
  endtask

  function automatic bit all_done();
    bit d;
    d = (m_owner < 0) && (bus.req_valid == '0);
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) d = 0;
    return d;
  endfunction

  task automatic start_phase();
    grant_log.delete();
    winc_cnt = 0;
  endtask

  // One clock: check outputs at negedge, advance the model, then update stimulus.
  task automatic cycle();
    int               o;
    logic [NREQ-1:0]  er;
    logic             ew;
    logic [DSIZE-1:0] ed;
    @(negedge wclk);
    o  = m_owner;
    er = '0;
    ew = 1'b0;
    ed = '0;
    if (o >= 0) begin
      if (!bus.wfull) er[o] = 1'b1;
      ew = bus.req_valid[o] && !bus.wfull;
      ed = bus.req_data[o*DSIZE +: DSIZE];
    end
    chk("busy", bus.busy, o >= 0);
    if (o >= 0) chk("grant_id", bus.grant_id, o);
    if (o >= 0) chk("burst_cnt", dbg_cnt, m_cnt);
    chk("req_ready", bus.req_ready, er);
    chk("winc", bus.winc, ew);
    chk("wdata", bus.wdata, ed);
    if (ew) exp_q.push_back(words[o][head[o]][DSIZE-1:0]);
    if (bus.winc === 1'b1) begin
      winc_cnt++;
      grant_log.push_back(int'(bus.grant_id));
      if (exp_q.size() == 0) chk("sb_underflow", bus.winc, 1'b0);
      else chk("sb_data", bus.wdata, exp_q.pop_front());
    end
    // Burst-level rules: pick next requester cyclically, end on last/MAXBURST/idle owner.
    if (o < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_rr + k) % NREQ;
        if (m_owner < 0 && bus.req_valid[c]) begin
          m_owner = c;
          m_cnt   = 0;
        end
      end
    end else if (ew) begin
      if (words[o][head[o]][DSIZE] || m_cnt == MAXBURST - 1) begin
        m_rr    = (o + 1) % NREQ;
        m_owner = -1;
      end else begin
        m_cnt++;
      end
    end else if (!bus.req_valid[o]) begin
      m_rr    = (o + 1) % NREQ;
      m_owner = -1;
    end
    @(posedge wclk);
    #1;
    if (ew) begin
      head[o]++;
      bus.req_valid[o] = 1'b0;
    end
    drive_reqs();
    if (full_pct > 0) bus.wfull = ($urandom_range(0, 99) < full_pct);
  endtask

  task automatic run_until_done(input int max_cyc, output int n);
    n = 0;
    while (!all_done() && n < max_cyc) begin
      cycle();
      n++;
    end
    chk("phase_done", all_done(), 1'b1);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_cnt   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    int total;
    checks    = 0;
    failures  = 0;
    valid_pct = 100;
    full_pct  = 0;
    wrst          = 1'b1;
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    bus.wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    model_reset();

    // Reset with every requester valid; then round-robin with last on every word.
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < NREQ; r++) push_word(r, 8'($urandom), 1'b1);
    drive_reqs();
    repeat (2) @(posedge wclk);
    @(negedge wclk);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_winc", bus.winc, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_wdata", bus.wdata, '0);
    chk("rst_state", dbg_state, 1'b0);
    @(posedge wclk);
    #1 wrst = 1'b0;
    start_phase();
    cycle();
    chk("first_grant_busy", bus.busy, 1'b1);
    chk("first_grant_id", bus.grant_id, 0);
    run_until_done(200, n);
    chk("rr_cycles", n + 1, 24);
    chk("rr_wincs", winc_cnt, 12);
    for (int i = 0; i < grant_log.size(); i++) chk("rr_order", grant_log[i], i % NREQ);

    // Lone requester 2: six words split 4 + 2 by the burst limit.
    start_phase();
    for (int k = 0; k < 6; k++) push_word(2, 8'($urandom), k == 5);
    drive_reqs();
    run_until_done(200, n);
    chk("burst_cycles", n, 8);
    chk("burst_wincs", winc_cnt, 6);
    for (int i = 0; i < grant_log.size(); i++) chk("burst_owner", grant_log[i], 2);

    // Owner 1 stalled by wfull for 5 cycles mid-burst.
    start_phase();
    for (int k = 0; k < 4; k++) push_word(1, 8'($urandom), k == 3);
    drive_reqs();
    repeat (3) cycle();
    bus.wfull = 1'b1;
    repeat (5) begin
      cycle();
      chk("full_winc", bus.winc, 1'b0);
      chk("full_grant", bus.grant_id, 1);
      chk("full_cnt", dbg_cnt, 2);
    end
    bus.wfull = 1'b0;
    run_until_done(200, n);
    chk("full_wincs", winc_cnt, 4);

    // Owner 3 goes idle after one word; pending requester 0 follows.
    start_phase();
    push_word(3, 8'($urandom), 1'b0);
    push_word(0, 8'($urandom), 1'b1);
    drive_reqs();
    run_until_done(200, n);
    chk("idle_cycles", n, 5);
    chk("idle_log_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("idle_first", grant_log[0], 3);
      chk("idle_second", grant_log[1], 0);
    end

    // Reset in the middle of a burst from requester 2.
    start_phase();
    for (int k = 0; k < 4; k++) push_word(2, 8'($urandom), k == 3);
    drive_reqs();
    repeat (2) cycle();
    wrst = 1'b1;
    #1;
    chk("mid_rst_winc", bus.winc, 1'b0);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_state", dbg_state, 1'b0);
    chk("mid_rst_rr", dbg_rr, 0);
    model_reset();
    push_word(0, 8'($urandom), 1'b1);
    drive_reqs();
    @(posedge wclk);
    #1 wrst = 1'b0;
    start_phase();
    run_until_done(200, n);
    chk("rst_restart_cycles", n, 6);
    chk("rst_restart_wincs", winc_cnt, 4);
    if (grant_log.size() > 0) chk("rst_restart_first", grant_log[0], 0);

    // Random traffic: random lengths, lasts, valid gaps and full stalls.
    start_phase();
    total = 0;
    for (int r = 0; r < NREQ; r++) begin
      int len;
      len = $urandom_range(0, 12);
      for (int k = 0; k < len; k++) push_word(r, 8'($urandom), $urandom_range(0, 3) == 0);
      total += len;
    end
    valid_pct = 60;
    full_pct  = 25;
    drive_reqs();
    run_until_done(3000, n);
    full_pct  = 0;
    bus.wfull = 1'b0;
    chk("rand_wincs", winc_cnt, total);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
